// File: rtl/psram_controller.sv
// Bridges a 32-bit word request onto an asynchronous 16-bit PSRAM as two timed
// halfword cycles (low half first), returning read data with a one-cycle ack.
module psram_controller #(
  parameter int T_ACCESS  = 4,
  parameter int T_RECOVER = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stb_i,
  input  logic        we_i,
  input  logic [20:0] addr_i,
  input  logic [3:0]  wbe_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        ack_o,
  output logic        psram_cen,
  output logic        psram_wen,
  output logic        psram_oen,
  output logic        psram_lbn,
  output logic        psram_ubn,
  output logic [21:0] psram_a,
  inout  wire  [15:0] psram_d
);

  typedef enum logic [2:0] {
    IDLE,
    ACC_LO,
    REC,
    ACC_HI,
    ACK
  } state_t;

  localparam logic [3:0] ACC_LAST = 4'(T_ACCESS - 1);
  localparam logic [3:0] REC_LAST = 4'(T_RECOVER - 1);

  state_t      r_state;
  state_t      w_state_next;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_next;
  logic        r_we;
  logic [20:0] r_addr;
  logic [3:0]  r_wbe;
  logic [31:0] r_data;
  logic        r_hi_en;
  logic [31:0] r_data_o;

  logic        w_lo_en_in;
  logic        w_hi_en_in;
  logic        w_in_acc;
  logic        w_hi_phase;
  logic        w_last_acc;
  logic [1:0]  w_be;
  logic        w_drive;
  logic [15:0] w_wdata;

  // Half enables are decided from the live inputs at the accepting edge.
  assign w_lo_en_in = !we_i || (wbe_i[1:0] != 2'b00);
  assign w_hi_en_in = !we_i || (wbe_i[3:2] != 2'b00);

  assign w_in_acc   = (r_state == ACC_LO) || (r_state == ACC_HI);
  assign w_hi_phase = (r_state == ACC_HI);
  assign w_last_acc = w_in_acc && (r_cnt == ACC_LAST);

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt + 4'd1;
    case (r_state)
      IDLE: begin
        w_cnt_next = 4'd0;
        if (stb_i) begin
          if (w_lo_en_in) begin
            w_state_next = ACC_LO;
          end else if (w_hi_en_in) begin
            w_state_next = ACC_HI;
          end else begin
            w_state_next = ACK;
          end
        end
      end
      ACC_LO: begin
        if (w_last_acc) begin
          w_cnt_next   = 4'd0;
          w_state_next = r_hi_en ? REC : ACK;
        end
      end
      REC: begin
        if (r_cnt == REC_LAST) begin
          w_cnt_next   = 4'd0;
          w_state_next = ACC_HI;
        end
      end
      ACC_HI: begin
        if (w_last_acc) begin
          w_cnt_next   = 4'd0;
          w_state_next = ACK;
        end
      end
      ACK: begin
        w_cnt_next   = 4'd0;
        w_state_next = IDLE;
      end
      default: begin
        w_cnt_next   = 4'd0;
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_we     <= 1'b0;
      r_addr   <= 21'd0;
      r_wbe    <= 4'd0;
      r_data   <= 32'd0;
      r_hi_en  <= 1'b0;
      r_data_o <= 32'd0;
    end else begin
      if ((r_state == IDLE) && stb_i) begin
        r_we    <= we_i;
        r_addr  <= addr_i;
        r_wbe   <= wbe_i;
        r_data  <= data_i;
        r_hi_en <= w_hi_en_in;
      end
      // The device has had the whole phase to settle; sample on its final cycle.
      if (!r_we && w_last_acc) begin
        if (w_hi_phase) begin
          r_data_o[31:16] <= psram_d;
        end else begin
          r_data_o[15:0] <= psram_d;
        end
      end
    end
  end

  assign w_be    = w_hi_phase ? r_wbe[3:2] : r_wbe[1:0];
  assign w_drive = w_in_acc && r_we;
  assign w_wdata = w_hi_phase ? r_data[31:16] : r_data[15:0];

  assign psram_cen = !w_in_acc;
  assign psram_oen = !(w_in_acc && !r_we);
  // Releasing write enable one cycle early leaves a data-hold cycle before cen rises.
  assign psram_wen = !(w_drive && !w_last_acc);
  assign psram_lbn = !(w_in_acc && (!r_we || w_be[0]));
  assign psram_ubn = !(w_in_acc && (!r_we || w_be[1]));
  assign psram_a   = w_in_acc ? {r_addr, w_hi_phase} : 22'd0;
  assign psram_d   = w_drive ? w_wdata : 16'bz;

  assign ack_o  = (r_state == ACK);
  assign data_o = r_data_o;

endmodule
